spi_flash_sched: RTL



---
 rtl/spi_flash_sched.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_sched.sv
// rtl/spi_flash_sched.sv - round-robin SPI flash command scheduler with WREN insertion and WIP polling
//
// Shares the spi_flash core's single 40-bit command port between NUM_REQ
// requesters. Write-class opcodes get a WREN in front of them. After the
// command, RDSR is polled until WIP clears, so each request completes as one
// atomic operation from the requester's point of view.
//
// Optional feature macro: SPI_SCHED_WEL_CHK_EN. When it is defined, WEL is
// read back after every WREN and the WREN is retried, up to 3 attempts in all.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_cmd, req_vld   per-requester {cmd, addr, data} and valid
//   req_rdy            one-hot (or zero) accept, combinational in IDLE
//   done_vld, done_err one-cycle completion pulse to the owner; err = timeout / WEL failure
//   rsp_data/vld/id    read bytes forwarded from the core, tagged with the owner index
//   cmd_out/vld/rdy    command handshake towards the core
//   flash_rdata/vld    bytes returned by the core
//   flash_idle         core idle (cs_n high, no transaction)
module spi_flash_sched #(
  parameter int CMD_WD   = 8,
  parameter int ADDR_WD  = 24,
  parameter int DATA_WD  = 8,
  parameter int TOL_WD   = 40,
  parameter int NUM_REQ  = 2,
  parameter int POLL_GAP = 64,
  parameter int POLL_MAX = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*TOL_WD-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        done_vld,
  output logic                      done_err,
  output logic [DATA_WD-1:0]        rsp_data,
  output logic                      rsp_vld,
  output logic [1:0]                rsp_id,
  output logic [TOL_WD-1:0]         cmd_out,
  output logic                      cmd_out_vld,
  input  logic                      cmd_out_rdy,
  input  logic [DATA_WD-1:0]        flash_rdata,
  input  logic                      flash_rdata_vld,
  input  logic                      flash_idle
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_WEL_ISSUE,
    S_WEL_WAIT,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_GAP,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_DONE
  } state_t;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TOL_WD-1:0] WREN_WORD = {CMD_WD'(8'h06), {(ADDR_WD+DATA_WD){1'b0}}};
  localparam logic [TOL_WD-1:0] RDSR_WORD = {CMD_WD'(8'h05), {(ADDR_WD+DATA_WD){1'b0}}};
  localparam logic [15:0]       POLL_LIM  = 16'(POLL_MAX);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

  function automatic logic is_write(input logic [CMD_WD-1:0] op);
    case (op)
      CMD_WD'(8'h02), CMD_WD'(8'h38), CMD_WD'(8'h20), CMD_WD'(8'h52),
      CMD_WD'(8'hD8), CMD_WD'(8'h60), CMD_WD'(8'hC7), CMD_WD'(8'h01): is_write = 1'b1;
      default:                                                        is_write = 1'b0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr;
  logic [1:0]          grant_q, grant_c;
  logic                found;
  logic [TOL_WD-1:0]   cmd_q, sel_cmd;
  logic                wr_q;
  logic [15:0]         poll_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                err_q;
  logic [DATA_WD-1:0]  sts_q, sts_now;
  logic                sts_got;
  logic                fire;
`ifdef SPI_SCHED_WEL_CHK_EN
  logic [1:0]          wren_try;
`endif

  assign fire = cmd_out_vld & cmd_out_rdy;

  // Only the first status beat of an RDSR counts; it may arrive in the same
  // cycle that flash_idle is seen, so look through to the live byte.
  assign sts_now = (flash_rdata_vld && !sts_got) ? flash_rdata : sts_q;

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    found   = 1'b0;
    grant_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_vld[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          found   = 1'b1;
          grant_c = 2'(i);
        end
      end
    end
  end

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c == 2'(i)) sel_cmd = req_cmd[i*TOL_WD +: TOL_WD];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_rdy     = '0;
    done_vld    = '0;
    done_err    = 1'b0;
    cmd_out     = '0;
    cmd_out_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated with rst so nothing is offered while the block is held in reset.
        if (found && !rst) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c == 2'(i)) req_rdy[i] = 1'b1;
          end
          state_d = is_write(sel_cmd[TOL_WD-1 -: CMD_WD]) ? S_WREN_ISSUE : S_CMD_ISSUE;
        end
      end
      S_WREN_ISSUE: begin
        cmd_out     = WREN_WORD;
        cmd_out_vld = 1'b1;
        if (cmd_out_rdy) state_d = S_WREN_WAIT;
      end
      S_WREN_WAIT: begin
        if (flash_idle) begin
`ifdef SPI_SCHED_WEL_CHK_EN
          state_d = S_WEL_ISSUE;
`else
          state_d = S_CMD_ISSUE;
`endif
        end
      end
`ifdef SPI_SCHED_WEL_CHK_EN
      S_WEL_ISSUE: begin
        cmd_out     = RDSR_WORD;
        cmd_out_vld = 1'b1;
        if (cmd_out_rdy) state_d = S_WEL_WAIT;
      end
      S_WEL_WAIT: begin
        if (flash_idle) begin
          if (sts_now[1])           state_d = S_CMD_ISSUE;
          else if (wren_try == 2'd3) state_d = S_DONE;
          else                      state_d = S_WREN_ISSUE;
        end
      end
`endif
      S_CMD_ISSUE: begin
        cmd_out     = cmd_q;
        cmd_out_vld = 1'b1;
        if (cmd_out_rdy) state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (flash_idle) state_d = wr_q ? S_GAP : S_DONE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_POLL_ISSUE;
      end
      S_POLL_ISSUE: begin
        cmd_out     = RDSR_WORD;
        cmd_out_vld = 1'b1;
        if (cmd_out_rdy) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (flash_idle) begin
          if (!sts_now[0])             state_d = S_DONE;
          else if (poll_cnt == POLL_LIM) state_d = S_DONE;
          else                         state_d = S_GAP;
        end
      end
      S_DONE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 2'(i)) done_vld[i] = 1'b1;
        end
        done_err = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      cmd_q    <= '0;
      wr_q     <= 1'b0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      err_q    <= 1'b0;
      sts_q    <= '0;
      sts_got  <= 1'b0;
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef SPI_SCHED_WEL_CHK_EN
      wren_try <= '0;
`endif
    end else begin
      state_q <= state_d;

      // Read data of the user command is forwarded one cycle after each beat.
      rsp_vld <= (state_q == S_CMD_WAIT) && flash_rdata_vld;
      if ((state_q == S_CMD_WAIT) && flash_rdata_vld) begin
        rsp_data <= flash_rdata;
        rsp_id   <= grant_q;
      end

      if ((state_q == S_IDLE) && (|req_rdy)) begin
        cmd_q   <= sel_cmd;
        grant_q <= grant_c;
        wr_q    <= is_write(sel_cmd[TOL_WD-1 -: CMD_WD]);
        rr_ptr  <= (int'(grant_c) == NUM_REQ - 1) ? 2'd0 : grant_c + 2'd1;
      end

      if ((state_q == S_GAP) && (state_d == S_GAP)) gap_cnt <= gap_cnt + 1'b1;
      else                                            gap_cnt <= '0;

      if ((state_q == S_POLL_ISSUE) && fire && (poll_cnt != POLL_LIM)) poll_cnt <= poll_cnt + 16'd1;

      if (((state_q == S_POLL_ISSUE) || (state_q == S_WEL_ISSUE)) && fire) begin
        sts_got <= 1'b0;
        sts_q   <= '0;
      end else if (((state_q == S_POLL_WAIT) || (state_q == S_WEL_WAIT)) &&
                   flash_rdata_vld && !sts_got) begin
        sts_got <= 1'b1;
        sts_q   <= flash_rdata;
      end

      if ((state_q == S_POLL_WAIT) && flash_idle && sts_now[0] && (poll_cnt == POLL_LIM))
        err_q <= 1'b1;

`ifdef SPI_SCHED_WEL_CHK_EN
      if ((state_q == S_WREN_ISSUE) && fire) wren_try <= wren_try + 2'd1;
      if ((state_q == S_WEL_WAIT) && flash_idle && !sts_now[1] && (wren_try == 2'd3))
        err_q <= 1'b1;
`endif

      if (state_q == S_DONE) begin
        poll_cnt <= '0;
        err_q    <= 1'b0;
        sts_got  <= 1'b0;
        sts_q    <= '0;
`ifdef SPI_SCHED_WEL_CHK_EN
        wren_try <= '0;
`endif
      end
    end
  end

endmodule
